// File: rtl/snake_pkg.sv
// snake_pkg: shared definitions for the snake datapath and the collision stage.
//   - coordinate width, segment record (x,y)
//   - direction encoding (0 up, 1 down, 2 left, 3 right)
//   - playfield wall constants X_MIN/X_MAX/Y_MIN/Y_MAX
//   - mover FSM state encoding
package snake_pkg;

    localparam int COORD_W = 20;

    localparam logic [COORD_W-1:0] X_MIN = 20'd0;
    localparam logic [COORD_W-1:0] X_MAX = 20'd624;
    localparam logic [COORD_W-1:0] Y_MIN = 20'd0;
    localparam logic [COORD_W-1:0] Y_MAX = 20'd464;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_SCAN = 2'd2
    } state_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } seg_t;

    // Opposite directions share the axis bit and differ in the sense bit.
    function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

endpackage

// File: rtl/snake_if.sv
// snake_if: game-side signals of the snake mover.
//   master: game logic / timer side (drives tick, dir, grow, freeze)
//   slave : snake_mover (drives head, body scan, scan_done, length)
interface snake_if;
    logic                         tick;
    logic [1:0]                   dir_in;
    logic                         dir_valid;
    logic                         grow;
    logic                         freeze;
    logic [snake_pkg::COORD_W-1:0] headX;
    logic [snake_pkg::COORD_W-1:0] headY;
    logic [snake_pkg::COORD_W-1:0] bodyX;
    logic [snake_pkg::COORD_W-1:0] bodyY;
    logic                         body_valid;
    logic                         scan_done;
    logic [4:0]                   length;

    modport master (
        output tick, dir_in, dir_valid, grow, freeze,
        input  headX, headY, bodyX, bodyY, body_valid, scan_done, length
    );

    modport slave (
        input  tick, dir_in, dir_valid, grow, freeze,
        output headX, headY, bodyX, bodyY, body_valid, scan_done, length
    );
endinterface

// File: rtl/snake_seg_store.sv
// snake_seg_store: MAX_LEN x 40-bit segment shift array, entry 0 is the head.
//   clk, reset_n : clock, synchronous active-low reset (loads the start pose)
//   i_shift      : seg[0] <= i_head, seg[i] <= seg[i-1]
//   i_head       : new head position
//   i_rd_idx     : combinational read index
//   o_head       : seg[0]
//   o_rd         : seg[i_rd_idx]
module snake_seg_store
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int STEP    = 16,
    parameter int START_X = 400,
    parameter int START_Y = 304,
    parameter int IDX_W   = $clog2(MAX_LEN)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_shift,
    input  seg_t             i_head,
    input  logic [IDX_W-1:0] i_rd_idx,
    output seg_t             o_head,
    output seg_t             o_rd
);

    seg_t r_seg [MAX_LEN];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // Body trails straight left of the head; entries beyond the
            // visible length are never exposed (growth keeps the old tail).
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg[i].x <= COORD_W'(START_X - i * STEP);
                r_seg[i].y <= COORD_W'(START_Y);
            end
        end else if (i_shift) begin
            r_seg[0] <= i_head;
            for (int i = 1; i < MAX_LEN; i++) begin
                r_seg[i] <= r_seg[i-1];
            end
        end
    end

    assign o_head = r_seg[0];
    assign o_rd   = r_seg[i_rd_idx];

endmodule

// File: rtl/snake_mover.sv
// snake_mover: moves the snake one STEP per accepted tick, then presents
// every body segment (1..length-1) to the collision stage, one per cycle.
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : tick/dir_in/dir_valid/grow/freeze in;
//                  headX/headY, bodyX/bodyY/body_valid, scan_done, length out
// Build option: define SNAKE_WRAP_EN to wrap the head at the playfield walls;
// otherwise the head moves freely (modulo 2^20) and walls are judged downstream.
module snake_mover
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int STEP    = 16,
    parameter int START_X = 400,
    parameter int START_Y = 304
) (
    input  logic clk,
    input  logic reset_n,
    snake_if.slave bus
);

    localparam int                 IDX_W   = $clog2(MAX_LEN);
    localparam logic [4:0]         LEN_MAX = 5'(MAX_LEN);
    localparam logic [COORD_W-1:0] STEP_C  = COORD_W'(STEP);

    state_e           r_state, w_state_nxt;
    dir_e             r_dir, r_dir_req, w_dir_nxt, w_dir_cur;
    logic             r_dir_pend, r_tick_pend, r_grow_pend, r_scan_done;
    logic [4:0]       r_len;
    logic [IDX_W-1:0] r_idx, w_last_idx;
    logic             w_shift, w_body_valid, w_scan_last;
    seg_t             w_head, w_head_nxt, w_rd;

    snake_seg_store #(
        .MAX_LEN (MAX_LEN),
        .STEP    (STEP),
        .START_X (START_X),
        .START_Y (START_Y),
        .IDX_W   (IDX_W)
    ) u_store (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_shift  (w_shift),
        .i_head   (w_head_nxt),
        .i_rd_idx (r_idx),
        .o_head   (w_head),
        .o_rd     (w_rd)
    );

    // ---------------- FSM ----------------
    assign w_last_idx = IDX_W'(r_len - 5'd1);

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shift      = 1'b0;
        w_body_valid = 1'b0;
        w_scan_last  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((bus.tick || r_tick_pend) && !bus.freeze) w_state_nxt = ST_MOVE;
            end
            ST_MOVE: begin
                w_shift     = 1'b1;
                w_state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                w_body_valid = 1'b1;
                if (r_idx == w_last_idx) begin
                    w_scan_last = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- scan index, scan_done, held tick ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_idx       <= '0;
            r_scan_done <= 1'b0;
            r_tick_pend <= 1'b0;
        end else begin
            r_scan_done <= w_scan_last;
            if (w_shift)           r_idx <= IDX_W'(1);
            else if (w_body_valid) r_idx <= r_idx + 1'b1;
            // IDLE always consumes (or, under freeze, discards) a held tick.
            if (bus.freeze || r_state == ST_IDLE) r_tick_pend <= 1'b0;
            else if (bus.tick)                    r_tick_pend <= 1'b1;
        end
    end

    // ---------------- direction ----------------
    assign w_dir_nxt = r_dir_pend ? r_dir_req : r_dir;
    // A request made during MOVE is judged against the heading being committed.
    assign w_dir_cur = (r_state == ST_MOVE) ? w_dir_nxt : r_dir;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_dir      <= DIR_RIGHT;
            r_dir_req  <= DIR_RIGHT;
            r_dir_pend <= 1'b0;
        end else begin
            if (w_shift) begin
                r_dir      <= w_dir_nxt;
                r_dir_pend <= 1'b0;
            end
            if (bus.dir_valid && !is_reverse(bus.dir_in, w_dir_cur)) begin
                r_dir_req  <= dir_e'(bus.dir_in);
                r_dir_pend <= 1'b1;
            end
        end
    end

    // ---------------- growth ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_len       <= 5'd3;
            r_grow_pend <= 1'b0;
        end else begin
            if (w_shift) begin
                r_grow_pend <= 1'b0;
                // Length grows by exposing the old tail, which the shift keeps.
                if (r_grow_pend && r_len < LEN_MAX) r_len <= r_len + 5'd1;
            end
            if (bus.grow && r_len != LEN_MAX) r_grow_pend <= 1'b1;
        end
    end

    // ---------------- next head ----------------
    always_comb begin
        w_head_nxt = w_head;
        case (w_dir_nxt)
            DIR_UP:   w_head_nxt.y = w_head.y - STEP_C;
            DIR_DOWN: w_head_nxt.y = w_head.y + STEP_C;
            DIR_LEFT: w_head_nxt.x = w_head.x - STEP_C;
            default:  w_head_nxt.x = w_head.x + STEP_C;
        endcase
`ifdef SNAKE_WRAP_EN
        // Compare before stepping so unsigned underflow never hides a wall.
        case (w_dir_nxt)
            DIR_UP:   if (w_head.y < Y_MIN + STEP_C) w_head_nxt.y = Y_MAX;
            DIR_DOWN: if (w_head.y > Y_MAX - STEP_C) w_head_nxt.y = Y_MIN;
            DIR_LEFT: if (w_head.x < X_MIN + STEP_C) w_head_nxt.x = X_MAX;
            default:  if (w_head.x > X_MAX - STEP_C) w_head_nxt.x = X_MIN;
        endcase
`endif
    end

    // ---------------- outputs ----------------
    assign bus.headX      = w_head.x;
    assign bus.headY      = w_head.y;
    assign bus.bodyX      = w_body_valid ? w_rd.x : '0;
    assign bus.bodyY      = w_body_valid ? w_rd.y : '0;
    assign bus.body_valid = w_body_valid;
    assign bus.scan_done  = r_scan_done;
    assign bus.length     = r_len;

endmodule

// File: tb/tb_snake_mover.sv
// tb_snake_mover: table-driven moves, hand-written corner sequences and a
// random run, all checked against a queue-based model of the snake.
module tb_snake_mover;

    localparam int MAXL = 16;
    localparam int STP  = 16;
    localparam int SX   = 400;
    localparam int SY   = 304;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    snake_if bus();

    snake_mover #(.MAX_LEN(MAXL), .STEP(STP), .START_X(SX), .START_Y(SY)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- model: segment queue, head first ----------------
    int mx[$];
    int my[$];
    int mdir, mreq;
    bit mpend, mgrow;

    function automatic void m_reset();
        mx.delete(); my.delete();
        for (int i = 0; i < 3; i++) begin
            mx.push_back(SX - i * STP);
            my.push_back(SY);
        end
        mdir = 3; mreq = 3; mpend = 0; mgrow = 0;
    endfunction

    function automatic void m_req(input int d);
        if (!((d / 2 == mdir / 2) && d != mdir)) begin
            mreq = d; mpend = 1;
        end
    endfunction

    function automatic void m_grow();
        if (mx.size() < MAXL) mgrow = 1;
    endfunction

    function automatic void m_move();
        int nx, ny;
        if (mpend) mdir = mreq;
        mpend = 0;
        nx = mx[0]; ny = my[0];
        case (mdir)
            0: ny = ny - STP;
            1: ny = ny + STP;
            2: nx = nx - STP;
            default: nx = nx + STP;
        endcase
`ifdef SNAKE_WRAP_EN
        if (nx > int'(snake_pkg::X_MAX)) nx = int'(snake_pkg::X_MIN);
        if (nx < int'(snake_pkg::X_MIN)) nx = int'(snake_pkg::X_MAX);
        if (ny > int'(snake_pkg::Y_MAX)) ny = int'(snake_pkg::Y_MIN);
        if (ny < int'(snake_pkg::Y_MIN)) ny = int'(snake_pkg::Y_MAX);
`endif
        mx.push_front(nx & 'hFFFFF);
        my.push_front(ny & 'hFFFFF);
        if (mgrow) mgrow = 0;
        else begin
            void'(mx.pop_back());
            void'(my.pop_back());
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit t, input bit dv, input bit [1:0] d, input bit g, input bit f);
        bus.tick = t; bus.dir_valid = dv; bus.dir_in = d; bus.grow = g; bus.freeze = f;
        cyc();
        bus.tick = 0; bus.dir_valid = 0; bus.grow = 0; bus.freeze = 0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        bus.tick = 0; bus.dir_valid = 0; bus.dir_in = 0; bus.grow = 0; bus.freeze = 0;
        cyc(); cyc();
        reset_n = 1;
        m_reset();
    endtask

    // Called while the DUT is in its MOVE cycle; runs the scan against the model.
    // tinj/finj inject tick/freeze during scan cycle i.
    task automatic scan_check(input string tag, input bit [15:0] tinj, input bit [15:0] finj);
        cyc();
        chk({tag, "_headX"}, bus.headX, mx[0]);
        chk({tag, "_headY"}, bus.headY, my[0]);
        chk({tag, "_len"}, bus.length, mx.size());
        for (int i = 1; i < mx.size(); i++) begin
            chk($sformatf("%s_bv_sd%0d", tag, i), {bus.body_valid, bus.scan_done}, 2'b10);
            chk($sformatf("%s_bx%0d", tag, i), bus.bodyX, mx[i]);
            chk($sformatf("%s_by%0d", tag, i), bus.bodyY, my[i]);
            bus.tick = tinj[i]; bus.freeze = finj[i];
            cyc();
            bus.tick = 0; bus.freeze = 0;
        end
        chk({tag, "_done"}, {bus.body_valid, bus.scan_done}, 2'b01);
    endtask

    task automatic move_cmd(input string tag, input bit dv, input bit [1:0] d, input bit g);
        if (dv) m_req(d);
        if (g) m_grow();
        drive(1, dv, d, g, 0);
        m_move();
        scan_check(tag, 16'h0, 16'h0);
    endtask

    // Several idle cycles with no movement or scan activity.
    task automatic quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            chk({tag, "_quiet_bv_sd"}, {bus.body_valid, bus.scan_done}, 2'b00);
            chk({tag, "_quiet_hx"}, bus.headX, mx[0]);
        end
    endtask

    typedef struct {
        bit       dv;
        bit [1:0] dir;
        bit       grow;
        int       ex;
        int       ey;
        int       elen;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{0, 2'd0, 0, 416, 304, 3};  // plain move right
        tbl[1] = '{1, 2'd2, 0, 432, 304, 3};  // left while right: ignored
        tbl[2] = '{1, 2'd0, 0, 432, 288, 3};  // turn up
        tbl[3] = '{0, 2'd0, 1, 432, 272, 4};  // grow with tick
        tbl[4] = '{1, 2'd1, 0, 432, 256, 4};  // down while up: ignored
        tbl[5] = '{1, 2'd2, 0, 416, 256, 4};  // turn left
        tbl[6] = '{1, 2'd3, 0, 400, 256, 4};  // right while left: ignored
        tbl[7] = '{1, 2'd1, 1, 400, 272, 5};  // turn down and grow

        // ---- reset state ----
        do_reset();
        chk("rst_headX", bus.headX, 400);
        chk("rst_headY", bus.headY, 304);
        chk("rst_len", bus.length, 3);
        chk("rst_bv_sd", {bus.body_valid, bus.scan_done}, 2'b00);
        chk("rst_bodyX", bus.bodyX, 0);
        chk("rst_bodyY", bus.bodyY, 0);

        // ---- table-driven moves ----
        for (int k = 0; k < 8; k++) begin
            move_cmd($sformatf("tbl%0d", k), tbl[k].dv, tbl[k].dir, tbl[k].grow);
            chk($sformatf("tbl%0d_ex", k), bus.headX, tbl[k].ex);
            chk($sformatf("tbl%0d_ey", k), bus.headY, tbl[k].ey);
            chk($sformatf("tbl%0d_elen", k), bus.length, tbl[k].elen);
        end

        // ---- held tick during scan; a third tick in the window is dropped ----
        do_reset();
        drive(1, 0, 0, 0, 0);
        m_move();
        scan_check("pend1", 16'b0110, 16'h0);
        cyc();
        chk("pend_move_cycle", {bus.body_valid, bus.scan_done}, 2'b00);
        m_move();
        scan_check("pend2", 16'h0, 16'h0);
        chk("pend2_headX", bus.headX, 432);
        quiet("pend_drop", 4);

        // ---- freeze ----
        drive(1, 0, 0, 0, 1);
        quiet("frz_idle", 3);
        chk("frz_headX", bus.headX, 432);
        drive(1, 0, 0, 0, 0);
        m_move();
        scan_check("frz_scan", 16'b0010, 16'b0100);
        quiet("frz_cleared", 4);

        // ---- reset in the middle of a scan ----
        do_reset();
        drive(1, 0, 0, 0, 0);
        cyc();
        bus.dir_valid = 1; bus.dir_in = 2'd0;
        cyc();
        bus.dir_valid = 0;
        reset_n = 0;
        cyc();
        chk("mid_rst_bv_sd", {bus.body_valid, bus.scan_done}, 2'b00);
        chk("mid_rst_headX", bus.headX, 400);
        chk("mid_rst_headY", bus.headY, 304);
        chk("mid_rst_len", bus.length, 3);
        chk("mid_rst_bodyX", bus.bodyX, 0);
        reset_n = 1;
        m_reset();
        quiet("mid_rst_after", 3);
        move_cmd("post_rst", 0, 0, 0);
        chk("post_rst_hx", bus.headX, 416);
        chk("post_rst_hy", bus.headY, 304);

        // ---- length saturation ----
        do_reset();
        for (int k = 0; k < 16; k++) move_cmd($sformatf("sat%0d", k), 0, 0, 1);
        chk("sat_len", bus.length, 16);

`ifdef SNAKE_WRAP_EN
        // ---- wrap at the right wall ----
        do_reset();
        for (int k = 0; k < 14; k++) move_cmd($sformatf("wr%0d", k), 0, 0, 0);
        chk("wrap_at_max", bus.headX, snake_pkg::X_MAX);
        move_cmd("wrap", 0, 0, 0);
        chk("wrap_to_min", bus.headX, snake_pkg::X_MIN);
`endif

        // ---- random run ----
        do_reset();
        for (int k = 0; k < 60; k++) begin
            int gap;
            bit dv, g;
            bit [1:0] d;
            gap = $urandom_range(0, 2);
            for (int j = 0; j < gap; j++) begin
                dv = ($urandom_range(0, 2) == 0);
                d  = 2'($urandom_range(0, 3));
                g  = ($urandom_range(0, 5) == 0);
                if (dv) m_req(d);
                if (g) m_grow();
                drive(0, dv, d, g, 0);
            end
            dv = ($urandom_range(0, 1) == 0);
            d  = 2'($urandom_range(0, 3));
            g  = ($urandom_range(0, 3) == 0);
            move_cmd($sformatf("rnd%0d", k), dv, d, g);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
